// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART byte transmitter among NREQ requesters.
// Define UART_ARB_TIMEOUT_EN to build the WAIT_BUSY/WAIT_DONE watchdog that drives err.
module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 50000,
   parameter int TMO_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic               tx_send,
   output logic [DW-1:0]      tx_data,
   input  logic               tx_bussy,
   output logic               active,
   output logic               err
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   state_t          state, state_n;
   logic [PW-1:0]   ptr, win, pick, pick_inc;
   logic            found, tmo_hit;
   logic [DW-1:0]   sel_data;
   logic [NREQ-1:0] gnt_n, done_n;
   logic            tx_send_n, active_n, err_n;

   // Winner is the first set req bit scanning ptr, ptr+1, ... with explicit wrap at NREQ.
   always_comb begin
      logic [PW:0] sum;
      sum      = '0;
      pick     = '0;
      found    = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
         if (!found && req[sum[PW-1:0]]) begin
            found = 1'b1;
            pick  = sum[PW-1:0];
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++)
         if (pick == PW'(i)) sel_data = req_data[i*DW +: DW];
   end

   assign pick_inc = (pick == PW'(NREQ-1)) ? '0 : pick + PW'(1);

   // NOTE: state and all registered outputs use non-blocking assignments so every flop
   // samples pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // NOTE: every always_comb output gets a default before the case so no latch is inferred.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (found) state_n = LAUNCH;
         LAUNCH:    state_n = WAIT_BUSY;
         WAIT_BUSY: if (tx_bussy) state_n = WAIT_DONE;
                    else if (tmo_hit) state_n = IDLE;
         WAIT_DONE: if (!tx_bussy || tmo_hit) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_comb begin
      gnt_n     = '0;
      done_n    = '0;
      tx_send_n = 1'b0;
      err_n     = 1'b0;
      if (state == IDLE && found) begin
         gnt_n     = NREQ'(1) << pick;
         tx_send_n = 1'b1;
      end
      if (state == WAIT_DONE && !tx_bussy) done_n = NREQ'(1) << win;
      if (state == WAIT_BUSY && !tx_bussy && tmo_hit) err_n = 1'b1;
      if (state == WAIT_DONE && tx_bussy && tmo_hit)  err_n = 1'b1;
      active_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr     <= '0;
         win     <= '0;
         tx_data <= '0;
         gnt     <= '0;
         done    <= '0;
         tx_send <= 1'b0;
         active  <= 1'b0;
         err     <= 1'b0;
      end else begin
         gnt     <= gnt_n;
         done    <= done_n;
         tx_send <= tx_send_n;
         active  <= active_n;
         err     <= err_n;
         if (state == IDLE && found) begin
            win     <= pick;
            ptr     <= pick_inc;
            tx_data <= sel_data;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt;

   // Cleared in LAUNCH (entry to WAIT_BUSY) and on the busy rise; counts while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tmo_cnt <= '0;
      else if (state == LAUNCH || (state == WAIT_BUSY && tx_bussy))
         tmo_cnt <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE)
         tmo_cnt <= tmo_cnt + TMO_W'(1);
   end

   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT-1)) &&
                    (state == WAIT_BUSY || state == WAIT_DONE);
`else
   assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences,
// and randomized traffic checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt, done;
   logic               tx_send, tx_bussy, active, err;
   logic [DW-1:0]      tx_data;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(20), .TMO_W(16)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
      .tx_send(tx_send), .tx_data(tx_data), .tx_bussy(tx_bussy), .active(active), .err(err)
   );

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic [NREQ-1:0]    req;
      logic [NREQ*DW-1:0] data;
      int                 busy;
      logic [NREQ-1:0]    exp_gnt;
      logic [DW-1:0]      exp_data;
   } vec_t;

   vec_t vecs[8];

   // ---------------- transaction-level reference model ----------------
   logic [DW-1:0]   q [NREQ][$];
   int              m_ptr, cur_win, rise_at, fall_at, cyc, done_cnt;
   bit              cur_idle, arrivals_on;
   logic [NREQ-1:0] exp_gnt, exp_done;
   logic            exp_send, exp_active;
   logic [DW-1:0]   exp_data;
   int              glog[$];

   function automatic logic [NREQ-1:0] pending();
      logic [NREQ-1:0] p = '0;
      for (int i = 0; i < NREQ; i++) p[i] = (q[i].size() != 0);
      return p;
   endfunction

   function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < NREQ; i++) begin
         req[i] = (q[i].size() != 0);
         req_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
      end
   endtask

   task automatic predict(input logic [NREQ-1:0] nd, input bit nidle_in);
      bit nidle;
      int w;
      nidle    = nidle_in;
      exp_gnt  = '0;
      exp_send = 1'b0;
      if (cur_idle && pending() != '0) begin
         w        = rr_pick(m_ptr, pending());
         exp_gnt  = NREQ'(1) << w;
         exp_send = 1'b1;
         exp_data = q[w][0];
         cur_win  = w;
         m_ptr    = (w + 1) % NREQ;
         nidle    = 1'b0;
      end
      exp_done   = nd;
      exp_active = !nidle;
      cur_idle   = nidle;
   endtask

   task automatic eng_start();
      m_ptr = 0; cur_idle = 1'b1; rise_at = -1; fall_at = -1; cyc = 0; done_cnt = 0;
      glog.delete();
      tx_bussy = 1'b0;
      drive_reqs();
      predict('0, 1'b1);
   endtask

   task automatic eng_step();
      logic [NREQ-1:0] nd;
      bit nidle;
      int r;
      @(negedge clk);
      cyc++;
      check("cycle outputs {gnt,done,send,active,err}",
            64'({gnt, done, tx_send, active, err}),
            64'({exp_gnt, exp_done, exp_send, exp_active, 1'b0}));
      if (exp_send) begin
         check("tx_data at grant", 64'(tx_data), 64'(exp_data));
         glog.push_back(cur_win);
         void'(q[cur_win].pop_front());
         rise_at = cyc + int'($urandom_range(1, 3));
         fall_at = rise_at + int'($urandom_range(1, 6));
      end
      if (exp_done != '0) begin
         check("tx_data held until done", 64'(tx_data), 64'(exp_data));
         done_cnt++;
      end
      if (arrivals_on && $urandom_range(0, 3) == 0) begin
         r = int'($urandom_range(0, NREQ-1));
         if (q[r].size() < 3) q[r].push_back(DW'($urandom));
      end
      drive_reqs();
      nd    = '0;
      nidle = cur_idle;
      if (cyc == rise_at) tx_bussy = 1'b1;
      if (cyc == fall_at) begin
         tx_bussy = 1'b0;
         nd       = NREQ'(1) << cur_win;
         nidle    = 1'b1;
      end
      predict(nd, nidle);
   endtask

   task automatic eng_drain(input int limit);
      int n = 0;
      while (!(pending() == '0 && cur_idle && exp_done == '0 && !exp_send) && n < limit) begin
         eng_step();
         n++;
      end
      check("drain within cycle budget", 64'(n < limit), 64'(1));
   endtask

   function automatic logic [63:0] order_code();
      logic [63:0] c = '0;
      for (int i = 0; i < glog.size() && i < 15; i++) c = (c << 4) | 64'(glog[i] + 1);
      return c;
   endfunction

   // ---------------- directed helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = '0; req_data = '0; tx_bussy = 1'b0;
      for (int i = 0; i < NREQ; i++) q[i].delete();
      repeat (2) @(negedge clk);
      check("reset outputs", 64'({gnt, done, tx_send, tx_data, active, err}), 64'(0));
      rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      req = v.req; req_data = v.data;
      @(negedge clk);
      check("vec gnt", 64'(gnt), 64'(v.exp_gnt));
      check("vec tx_send", 64'(tx_send), 64'(1));
      check("vec tx_data", 64'(tx_data), 64'(v.exp_data));
      req = '0;
      @(negedge clk);
      tx_bussy = 1'b1;
      repeat (v.busy) @(negedge clk);
      check("vec busy window {active,done}", 64'({active, done}), 64'({1'b1, {NREQ{1'b0}}}));
      tx_bussy = 1'b0;
      @(negedge clk);
      check("vec done", 64'(done), 64'(v.exp_gnt));
      check("vec active after done", 64'(active), 64'(0));
      check("vec tx_data stable", 64'(tx_data), 64'(v.exp_data));
      @(negedge clk);
      check("vec done one cycle", 64'(done), 64'(0));
   endtask

   initial begin
      bit seen;
      int bad;
      vecs[0] = '{4'b0001, 32'h0000_00A5, 10, 4'b0001, 8'hA5};
      vecs[1] = '{4'b0001, 32'h0000_003C,  1, 4'b0001, 8'h3C};
      vecs[2] = '{4'b1001, 32'h7E00_00C3,  2, 4'b1000, 8'h7E};
      vecs[3] = '{4'b0110, 32'h00B2_D100,  4, 4'b0010, 8'hD1};
      vecs[4] = '{4'b0011, 32'h0000_5A96,  3, 4'b0001, 8'h96};
      vecs[5] = '{4'b1111, 32'hF0E1_D2C3,  1, 4'b0010, 8'hD2};
      vecs[6] = '{4'b0100, 32'h0088_0000,  5, 4'b0100, 8'h88};
      vecs[7] = '{4'b1111, 32'h1122_3344,  2, 4'b1000, 8'h11};

      rst = 1'b1; req = '0; req_data = '0; tx_bussy = 1'b0; arrivals_on = 1'b0;
      do_reset();
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset in WAIT_DONE after requester 1 won (ptr now 2).
      req = 4'b0010; req_data = 32'h0000_5500;
      @(negedge clk);
      check("pre-reset gnt", 64'(gnt), 64'(4'b0010));
      req = '0;
      @(negedge clk);
      tx_bussy = 1'b1;
      repeat (3) @(negedge clk);
      check("pre-reset active", 64'({active, tx_data}), 64'({1'b1, 8'h55}));
      #2 rst = 1'b1;
      #1 check("async reset outputs", 64'({gnt, done, tx_send, tx_data, active, err}), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tx_bussy = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | (|{done, gnt, active});
      end
      check("no done after reset", 64'(seen), 64'(0));
      run_vec('{4'b1001, 32'h7700_0042, 3, 4'b0001, 8'h42});

      // All four request at once from reset.
      do_reset();
      q[0].push_back(8'h11); q[1].push_back(8'h22); q[2].push_back(8'h33); q[3].push_back(8'h44);
      eng_start();
      eng_drain(200);
      check("all-four grant order", order_code(), 64'h1234);
      check("all-four done count", 64'(done_cnt), 64'(4));

      // Requester 2 keeps requesting while 0 and 3 request once.
      do_reset();
      q[0].push_back(8'hA0); q[3].push_back(8'hD3);
      q[2].push_back(8'hC1); q[2].push_back(8'hC2); q[2].push_back(8'hC3);
      eng_start();
      eng_drain(300);
      check("hog grant order", order_code(), 64'h13433);

      // Randomized traffic.
      do_reset();
      eng_start();
      arrivals_on = 1'b1;
      repeat (3000) eng_step();
      arrivals_on = 1'b0;
      eng_drain(400);
      check("random traffic produced grants", 64'(glog.size() > 50), 64'(1));

      // Transmitter never goes busy.
      do_reset();
      req = 4'b0011; req_data = 32'h0000_BBAA;
      @(negedge clk);
      check("stall gnt", 64'({gnt, tx_data}), 64'({4'b0001, 8'hAA}));
      req = 4'b0010;
`ifdef UART_ARB_TIMEOUT_EN
      seen = 1'b0;
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk);
         if (i < 21) seen = seen | err | (|done);
         if (i == 21) check("timeout err pulse", 64'({err, active, done}), 64'({1'b1, 1'b0, 4'b0000}));
         if (i == 22) check("next requester after timeout", 64'({gnt, err}), 64'({4'b0010, 1'b0}));
      end
      check("no early err or done", 64'(seen), 64'(0));
`else
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (!active || err || done != '0 || gnt != '0) bad++;
      end
      check("stuck in WAIT_BUSY without watchdog", 64'(bad), 64'(0));
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
